fht_twiddle_seq: RTL and testbench
==================================

FHT_TWIDDLE_SEQ -- requirements
Module: fht_twiddle_seq

Interface
REQ-001 SHALL have parameter A_BIT, default 10: twiddle ROM address width; the ROM holds a quarter wave [0, pi/2) in 2^A_BIT entries.
REQ-002 SHALL have parameter N_STAGE, default 11: FHT stage count (N = 2^N_STAGE); legal range 2..A_BIT+1.
REQ-003 SHALL have parameter S_BIT, default 4: stage index width, ceil(log2(N_STAGE)).
REQ-004 SHALL have parameter STAGE_GAP, default 2: idle cycles between stages; used only with FHT_TW_STAGE_GAP_EN.
REQ-005 SHALL have port iCLK, input, 1 bit: the single clock, rising edge.
REQ-006 SHALL have port iRESET, input, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL have port iSTART, input, 1 bit: one-cycle pulse that starts a transform.
REQ-008 SHALL have port iSTALL, input, 1 bit: datapath backpressure; freezes the whole block.
REQ-009 SHALL have port oADDR, output, A_BIT bits: address to fht_rom_block iADDR.
REQ-010 SHALL have port oSEL, output, 1 bit, ROM-aligned: 0 uses the SIN_0/COS_0 pair, 1 uses SIN_1/COS_1 (+pi/2).
REQ-011 SHALL have port oVALID, output, 1 bit: ROM q is valid this cycle (ROM-aligned).
REQ-012 SHALL have port oSTAGE, output, S_BIT bits, ROM-aligned: stage of the current twiddle.
REQ-013 SHALL have port oBUSY, output, 1 bit: high from the cycle after iSTART until oDONE.
REQ-014 SHALL have port oDONE, output, 1 bit: one-cycle pulse at the end of the transform.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, GAP, FLUSH, DONE.
REQ-016 In IDLE, iSTART=1 SHALL clear s=0, b=0 and move to RUN; iSTART outside IDLE SHALL be ignored.
REQ-017 RUN SHALL issue one butterfly per non-stalled cycle, b = 0..2^(N_STAGE-1)-1, with twiddle index k = b >> (N_STAGE-1-s), so each k repeats consecutively.
REQ-018 For k < 2^(s-1), issue SHALL be oADDR = k << (A_BIT-s+1), sel=0; otherwise oADDR = (k-2^(s-1)) << (A_BIT-s+1), sel=1; stage 0 SHALL issue addr 0, sel 0.
REQ-019 All shifts SHALL be truncated to A_BIT bits, and b and s SHALL use explicit widths with no implicit overflow.
REQ-020 ROM latency is 1 cycle, so oVALID, oSEL and oSTAGE SHALL be the issue-cycle values delayed by one register.
REQ-021 On the last b of a stage with s < N_STAGE-1, the FSM SHALL go to RUN (s+1, b=0) or to GAP.
REQ-022 On the last b of the last stage, the FSM SHALL go to FLUSH, one cycle for ROM drain, then DONE.
REQ-023 DONE SHALL pulse oDONE for one cycle, deassert oBUSY in the same cycle, and return to IDLE.
REQ-024 iSTALL=1 SHALL hold state, counters, oADDR and all delayed outputs unchanged; GAP and FLUSH counting SHALL also freeze.
REQ-025 The consumer accepts on oVALID & !iSTALL.
REQ-026 oADDR SHALL hold its last value while not in RUN, and oVALID=0 outside valid issues.

Reset
REQ-027 iRESET=0 at any rising edge SHALL force IDLE, s=0, b=0, oADDR=0, oSEL=0, oVALID=0, oSTAGE=0, oBUSY=0, oDONE=0, including mid-transform, with no oDONE emitted.
REQ-028 Reset SHALL take priority over iSTART and iSTALL.

Configuration
REQ-029 With macro FHT_TW_STAGE_GAP_EN defined, the FSM SHALL enter GAP between stages for exactly STAGE_GAP non-stalled cycles with oVALID=0.
REQ-030 Without FHT_TW_STAGE_GAP_EN, the GAP state and counter SHALL not exist, and stages SHALL run back-to-back with no bubble.

Structure
REQ-031 Package fht_pkg SHALL hold the FSM state enum type and the localparams for butterflies per stage and the shift amount function.
REQ-032 Sub-module fht_twiddle_addr SHALL be combinational: (s, b) -> (addr, sel).
REQ-033 fht_rom_block SHALL be instantiated by the parent, not inside this block.

Verification (A_BIT=10, N_STAGE=4, macro off unless stated)
REQ-034 iSTART at cycle 0 -> oVALID high cycles 2..33 (32 twiddles), oDONE pulse at cycle 35, oBUSY cycles 1..35.
REQ-035 Stage 2 -> (addr,sel) = (0,0),(0,0),(512,0),(512,0),(0,1),(0,1),(512,1),(512,1); stage 3 -> addr 0,256,512,768 with sel 0, then the same with sel 1.
REQ-036 iSTALL high 3 cycles during stage 1 -> all outputs frozen 3 cycles; total run extended by exactly 3 cycles; sequence unchanged.
REQ-037 iRESET=0 at cycle 10 -> next cycle all outputs 0, state IDLE; a later iSTART restarts from stage 0, addr 0.
REQ-038 iSTART repeated at cycle 5 while busy -> ignored; sequence and oDONE timing identical to REQ-034.
REQ-039 FHT_TW_STAGE_GAP_EN defined, STAGE_GAP=2 -> 2 oVALID=0 cycles after each of stages 0..2; oDONE at cycle 41.

Source files
------------

// File: rtl/fht_twiddle_seq_pkg.sv
// Shared state type and constant helpers for the FHT twiddle sequencer.
// The GAP state only exists when FHT_TW_STAGE_GAP_EN is defined.
package fht_pkg;

    localparam int DEF_A_BIT     = 10;
    localparam int DEF_N_STAGE   = 11;
    localparam int DEF_S_BIT     = 4;
    localparam int DEF_STAGE_GAP = 2;

`ifdef FHT_TW_STAGE_GAP_EN
    typedef enum logic [2:0] {
        IDLE,
        RUN,
        GAP,
        FLUSH,
        DONE
    } fht_state_t;
`else
    typedef enum logic [2:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } fht_state_t;
`endif

    // Butterflies issued per stage for an N = 2^n_stage point transform.
    function automatic int bfly_per_stage(input int n_stage);
        return 1 << (n_stage - 1);
    endfunction

    // Right shift turning a butterfly index into its twiddle index k.
    function automatic int k_shift(input int n_stage, input int s);
        return n_stage - 1 - s;
    endfunction

    // Left shift scaling k onto the quarter-wave ROM address range.
    function automatic int a_shift(input int a_bit, input int s);
        return a_bit - s + 1;
    endfunction

endpackage

// File: rtl/fht_twiddle_addr.sv
// Combinational twiddle address generator: (stage, butterfly) -> (ROM address, half select).
// Angles past pi/2 fold back onto the quarter-wave table with sel marking the +pi/2 pair.
module fht_twiddle_addr
    import fht_pkg::*;
#(
    parameter int A_BIT   = DEF_A_BIT,
    parameter int N_STAGE = DEF_N_STAGE,
    parameter int S_BIT   = DEF_S_BIT
) (
    input  logic [S_BIT-1:0]   s,
    input  logic [N_STAGE-2:0] b,
    output logic [A_BIT-1:0]   addr,
    output logic               sel
);

    localparam int B_W = N_STAGE - 1;
    localparam int W_W = A_BIT + B_W;

    logic [B_W-1:0] k;
    logic [B_W-1:0] half;
    logic [B_W-1:0] koff;

    always_comb begin
        k    = b >> k_shift(N_STAGE, int'(s));
        half = '0;
        koff = '0;
        sel  = 1'b0;
        addr = '0;
        // stage 0 always uses twiddle 0, and 2^(s-1) is undefined there
        if (s != '0) begin
            half = B_W'(1) << (int'(s) - 1);
            if (k < half) begin
                koff = k;
            end else begin
                koff = k - half;
                sel  = 1'b1;
            end
            addr = A_BIT'(W_W'(koff) << a_shift(A_BIT, int'(s)));
        end
    end

endmodule

// File: rtl/fht_twiddle_seq.sv
// FHT twiddle ROM sequencer: walks stages/butterflies, drives ROM address, aligns valid/sel/stage.
// Define FHT_TW_STAGE_GAP_EN to insert STAGE_GAP idle cycles between stages.
//
//   state | meaning
//   IDLE  | waiting for iSTART
//   RUN   | one butterfly twiddle issued per non-stalled cycle
//   GAP   | inter-stage bubble (FHT_TW_STAGE_GAP_EN only)
//   FLUSH | one cycle for the last ROM read to drain
//   DONE  | transform complete, oDONE pulses on the following cycle
module fht_twiddle_seq
    import fht_pkg::*;
#(
    parameter int A_BIT     = DEF_A_BIT,
    parameter int N_STAGE   = DEF_N_STAGE,
    parameter int S_BIT     = DEF_S_BIT,
    parameter int STAGE_GAP = DEF_STAGE_GAP
) (
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic             iSTART,
    input  logic             iSTALL,
    output logic [A_BIT-1:0] oADDR,
    output logic             oSEL,
    output logic             oVALID,
    output logic [S_BIT-1:0] oSTAGE,
    output logic             oBUSY,
    output logic             oDONE
);

    localparam int B_W = N_STAGE - 1;
    localparam logic [B_W-1:0]   B_LAST = B_W'(bfly_per_stage(N_STAGE) - 1);
    localparam logic [S_BIT-1:0] S_LAST = S_BIT'(N_STAGE - 1);

    fht_state_t       state, state_n;
    logic [S_BIT-1:0] s_q, s_n;
    logic [B_W-1:0]   b_q, b_n;
    logic [A_BIT-1:0] addr_w, addr_q;
    logic             sel_w;
    logic             issue;
    logic             valid_q, sel_q, busy_q, done_q;
    logic [S_BIT-1:0] stage_q;

`ifdef FHT_TW_STAGE_GAP_EN
    localparam int G_W = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
    logic [G_W-1:0]   gap_q, gap_n;
`endif

    fht_twiddle_addr #(
        .A_BIT   (A_BIT),
        .N_STAGE (N_STAGE),
        .S_BIT   (S_BIT)
    ) u_addr (
        .s    (s_q),
        .b    (b_q),
        .addr (addr_w),
        .sel  (sel_w)
    );

    assign issue = (state == RUN);
    // outside RUN the ROM keeps seeing the last issued address
    assign oADDR = issue ? addr_w : addr_q;

    always_comb begin
        state_n = state;
        s_n     = s_q;
        b_n     = b_q;
`ifdef FHT_TW_STAGE_GAP_EN
        gap_n   = gap_q;
`endif
        if (!iSTALL) begin
            case (state)
                IDLE: begin
                    if (iSTART) begin
                        state_n = RUN;
                        s_n     = '0;
                        b_n     = '0;
                    end
                end
                RUN: begin
                    if (b_q == B_LAST) begin
                        if (s_q == S_LAST) begin
                            state_n = FLUSH;
                        end else begin
                            s_n = s_q + 1'b1;
                            b_n = '0;
`ifdef FHT_TW_STAGE_GAP_EN
                            state_n = GAP;
                            gap_n   = G_W'(STAGE_GAP - 1);
`endif
                        end
                    end else begin
                        b_n = b_q + 1'b1;
                    end
                end
`ifdef FHT_TW_STAGE_GAP_EN
                GAP: begin
                    if (gap_q == '0) begin
                        state_n = RUN;
                    end else begin
                        gap_n = gap_q - 1'b1;
                    end
                end
`endif
                FLUSH:   state_n = DONE;
                DONE:    state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge iCLK) begin
        if (!iRESET) begin
            state   <= IDLE;
            s_q     <= '0;
            b_q     <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            sel_q   <= 1'b0;
            stage_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef FHT_TW_STAGE_GAP_EN
            gap_q   <= '0;
`endif
        end else if (!iSTALL) begin
            state   <= state_n;
            s_q     <= s_n;
            b_q     <= b_n;
            addr_q  <= oADDR;
            valid_q <= issue;
            sel_q   <= issue & sel_w;
            stage_q <= s_q;
            // busy covers the DONE state so it drops together with the oDONE pulse
            busy_q  <= (state != IDLE) | iSTART;
            done_q  <= (state == DONE);
`ifdef FHT_TW_STAGE_GAP_EN
            gap_q   <= gap_n;
`endif
        end
    end

    assign oSEL   = sel_q;
    assign oVALID = valid_q;
    assign oSTAGE = stage_q;
    assign oBUSY  = busy_q;
    assign oDONE  = done_q;

endmodule

// File: tb/tb_fht_twiddle_seq.sv
// Self-checking bench for fht_twiddle_seq (A_BIT=10, N_STAGE=4); follows FHT_TW_STAGE_GAP_EN if defined.
module tb_fht_twiddle_seq;

    localparam int A_BIT     = 10;
    localparam int N_STAGE   = 4;
    localparam int S_BIT     = 2;
    localparam int STAGE_GAP = 2;
    localparam int BF        = 1 << (N_STAGE - 1);
    localparam int Q         = 1 << A_BIT;
`ifdef FHT_TW_STAGE_GAP_EN
    localparam int GAPS = (N_STAGE - 1) * STAGE_GAP;
`else
    localparam int GAPS = 0;
`endif
    // non-stalled cycles from the iSTART cycle to the first oDONE cycle
    localparam int RUN_LEN = N_STAGE * BF + 3 + GAPS;

    logic             iCLK = 1'b0;
    logic             iRESET = 1'b0;
    logic             iSTART = 1'b0;
    logic             iSTALL = 1'b0;
    logic [A_BIT-1:0] oADDR;
    logic             oSEL;
    logic             oVALID;
    logic [S_BIT-1:0] oSTAGE;
    logic             oBUSY;
    logic             oDONE;

    always #5 iCLK = ~iCLK;

    fht_twiddle_seq #(
        .A_BIT     (A_BIT),
        .N_STAGE   (N_STAGE),
        .S_BIT     (S_BIT),
        .STAGE_GAP (STAGE_GAP)
    ) dut (
        .iCLK   (iCLK),
        .iRESET (iRESET),
        .iSTART (iSTART),
        .iSTALL (iSTALL),
        .oADDR  (oADDR),
        .oSEL   (oSEL),
        .oVALID (oVALID),
        .oSTAGE (oSTAGE),
        .oBUSY  (oBUSY),
        .oDONE  (oDONE)
    );

    typedef struct {
        int addr;
        int sel;
        int stage;
    } tw_t;

    typedef struct {
        int start2_at;
        int stall_at;
        int stall_len;
        int exp_first;
        int exp_last;
        int exp_done;
    } vec_t;

    tw_t  ref_q[$];
    tw_t  got_q[$];
    tw_t  sc0_q[$];
    vec_t vecs[4];

    int total = 0;
    int bad   = 0;
    int first_v, last_v, done_t, done_ns, done_pulses, busy_gaps;
    int last_addr = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge iCLK);
        #1;
    endtask

    // Twiddle of butterfly b in stage s is the angle 2*pi*k/2^(s+1), k = group index of b.
    // One ROM quarter is Q units, so a full turn is 4*Q units.
    task automatic build_ref();
        tw_t t;
        int  gsz, k, ang;
        ref_q.delete();
        for (int s = 0; s < N_STAGE; s++) begin
            for (int b = 0; b < BF; b++) begin
                gsz     = BF >> s;
                k       = b / gsz;
                ang     = (k * 4 * Q) / (2 << s);
                t.addr  = ang % Q;
                t.sel   = (ang >= Q) ? 1 : 0;
                t.stage = s;
                ref_q.push_back(t);
            end
        end
    endtask

    task automatic run_xfer(input int start2_at, input int stall_at, input int stall_len,
                            input bit rnd);
        int  ns;
        bit  seen_done;
        bit  fin;
        tw_t t;
        got_q.delete();
        first_v = -1; last_v = -1; done_t = -1; done_ns = -1;
        done_pulses = 0; busy_gaps = 0;
        ns = 0; seen_done = 1'b0; fin = 1'b0;
        for (int c = 0; c < 600 && !fin; c++) begin
            iSTART = (c == 0) || (c == start2_at);
            if (seen_done || c == 0)
                iSTALL = 1'b0;
            else
                iSTALL = (c >= stall_at && c < stall_at + stall_len) ||
                         (rnd && $urandom_range(0, 3) == 0);
            @(negedge iCLK);
            if (oVALID) begin
                if (first_v < 0) first_v = c;
                last_v = c;
            end
            if (oVALID && !iSTALL) begin
                t.addr  = last_addr;
                t.sel   = int'(oSEL);
                t.stage = int'(oSTAGE);
                got_q.push_back(t);
            end
            if (!iSTALL) last_addr = int'(oADDR);
            if (c > 0 && !seen_done && !oBUSY) busy_gaps++;
            if (oDONE && !seen_done) begin
                seen_done = 1'b1;
                done_t    = c;
                done_ns   = ns;
            end
            if (oDONE && !iSTALL) done_pulses++;
            if (seen_done && !oDONE) begin
                fin = 1'b1;
                chk("busy_after_done", int'(oBUSY), 0);
            end
            if (!iSTALL) ns++;
            step();
        end
        iSTART = 1'b0;
        iSTALL = 1'b0;
        if (!fin) chk("xfer_timeout", 0, 1);
    endtask

    task automatic check_stream(input string nm);
        int n;
        chk({nm, "_count"}, got_q.size(), ref_q.size());
        n = (got_q.size() < ref_q.size()) ? got_q.size() : ref_q.size();
        for (int i = 0; i < n; i++) begin
            if (got_q[i].addr != ref_q[i].addr || got_q[i].sel != ref_q[i].sel ||
                got_q[i].stage != ref_q[i].stage)
                $display("  %s entry %0d: addr=%0d sel=%0d stage=%0d", nm, i,
                         got_q[i].addr, got_q[i].sel, got_q[i].stage);
            chk({nm, "_addr"}, got_q[i].addr, ref_q[i].addr);
            chk({nm, "_sel"}, got_q[i].sel, ref_q[i].sel);
            chk({nm, "_stage"}, got_q[i].stage, ref_q[i].stage);
        end
    endtask

    initial begin
        int e2_addr[8];
        int e2_sel[8];
        int e3_addr[8];
        int e3_sel[8];
        int dcount;

        e2_addr = '{0, 0, 512, 512, 0, 0, 512, 512};
        e2_sel  = '{0, 0, 0, 0, 1, 1, 1, 1};
        e3_addr = '{0, 256, 512, 768, 0, 256, 512, 768};
        e3_sel  = '{0, 0, 0, 0, 1, 1, 1, 1};

        //            start2 stall_at len first last         done
        vecs[0] = '{-1, -1, 0, 2, 33 + GAPS, 35 + GAPS};
        vecs[1] = '{ 5, -1, 0, 2, 33 + GAPS, 35 + GAPS};
        vecs[2] = '{-1, 11, 3, 2, 36 + GAPS, 38 + GAPS};
        vecs[3] = '{-1,  1, 2, 4, 35 + GAPS, 37 + GAPS};

        build_ref();

        // reset state, with iSTART and iSTALL asserted to confirm reset priority
        iRESET = 1'b0;
        iSTART = 1'b1;
        iSTALL = 1'b1;
        repeat (3) step();
        @(negedge iCLK);
        chk("rst_addr", int'(oADDR), 0);
        chk("rst_sel", int'(oSEL), 0);
        chk("rst_valid", int'(oVALID), 0);
        chk("rst_stage", int'(oSTAGE), 0);
        chk("rst_busy", int'(oBUSY), 0);
        chk("rst_done", int'(oDONE), 0);
        iSTART = 1'b0;
        iSTALL = 1'b0;
        step();
        iRESET = 1'b1;
        step();

        // directed vectors
        for (int v = 0; v < 4; v++) begin
            run_xfer(vecs[v].start2_at, vecs[v].stall_at, vecs[v].stall_len, 1'b0);
            chk("first_valid", first_v, vecs[v].exp_first);
            chk("last_valid", last_v, vecs[v].exp_last);
            chk("done_cycle", done_t, vecs[v].exp_done);
            chk("done_pulses", done_pulses, 1);
            chk("busy_gaps", busy_gaps, 0);
            check_stream("vec_stream");
            if (v == 0) sc0_q = got_q;
            repeat (3) step();
        end

        // stage 2 and stage 3 twiddle patterns from the plain run
        chk("sc0_size", sc0_q.size(), 4 * BF);
        if (sc0_q.size() == 4 * BF) begin
            for (int i = 0; i < 8; i++) begin
                chk("st2_addr", sc0_q[16 + i].addr, e2_addr[i]);
                chk("st2_sel", sc0_q[16 + i].sel, e2_sel[i]);
                chk("st3_addr", sc0_q[24 + i].addr, e3_addr[i]);
                chk("st3_sel", sc0_q[24 + i].sel, e3_sel[i]);
            end
        end

        // reset in the middle of a transform
        iSTART = 1'b1;
        step();
        iSTART = 1'b0;
        repeat (9) step();
        @(negedge iCLK);
        chk("mid_busy", int'(oBUSY), 1);
        iRESET = 1'b0;
        step();
        iRESET = 1'b1;
        @(negedge iCLK);
        chk("mid_rst_outs", int'({oADDR, oSEL, oVALID, oSTAGE, oBUSY, oDONE}), 0);
        dcount = 0;
        for (int c = 0; c < 50; c++) begin
            step();
            @(negedge iCLK);
            if (oDONE || oVALID || oBUSY) dcount++;
        end
        chk("post_rst_quiet", dcount, 0);
        step();
        run_xfer(-1, -1, 0, 1'b0);
        chk("restart_done", done_t, 35 + GAPS);
        chk("restart_first_addr", (got_q.size() > 0) ? got_q[0].addr : -1, 0);
        check_stream("restart_stream");
        repeat (2) step();

        // randomized stalls and stray iSTART pulses against the reference model
        for (int r = 0; r < 6; r++) begin
            run_xfer($urandom_range(1, 20), -1, 0, 1'b1);
            chk("rnd_done_ns", done_ns, RUN_LEN);
            chk("rnd_done_pulses", done_pulses, 1);
            chk("rnd_busy_gaps", busy_gaps, 0);
            check_stream("rnd_stream");
            repeat ($urandom_range(1, 4)) step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
